apb4_master_bridge: RTL
=======================

APB4_MASTER_BRIDGE -- requirements
Module: apb4_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: request and PADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; the strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT, default 255: the maximum number of ACCESS cycles waiting for pready_i before abort; legal range is 1..65535.
REQ-004 SHALL have one clock and a synchronous, active-low reset; ports are listed below.
- clk_i  in  1  clock; all logic is on the rising edge
- rst_n_i  in  1  synchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid and ready are both 1
- req_write_i  in  1  1=write, 0=read
- req_addr_i  in  ADDR_WIDTH  byte address
- req_wdata_i  in  DATA_WIDTH  write data
- req_wstrb_i  in  DATA_WIDTH/8  write strobes
- req_prot_i  in  3  protection attribute
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- resp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and for timeouts
- resp_err_o  out  1  pslverr_i or timeout
- resp_timeout_o  out  1  the error was caused by a timeout
- paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o  out  APB4 master outputs
- pready_i, prdata_i, pslverr_i  in  APB4 completer inputs

Function
REQ-005 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-006 SHALL drive req_ready_o=1 only in IDLE; a handshake latches write, addr, wdata, wstrb and prot, then moves to SETUP.
REQ-007 SETUP SHALL drive psel_o=1 and penable_o=0 for exactly one cycle, then move to ACCESS.
REQ-008 ACCESS SHALL drive psel_o=1 and penable_o=1; all APB outputs SHALL stay stable from SETUP until the completion of ACCESS.
REQ-009 ACCESS SHALL complete on pready_i=1, capturing prdata_i (reads only) and pslverr_i, then move to RESP.
REQ-010 SHALL drive pstrb_o=0 on reads and pwdata_o=0 on reads.
REQ-011 SHALL count ACCESS cycles; when the count reaches TIMEOUT and pready_i=0, it SHALL abort the transfer: psel_o=0 the next cycle, state RESP, resp_err_o=1, resp_timeout_o=1, resp_rdata_o=0.
REQ-012 SHALL give priority to pready_i=1 over timeout when both occur in the same cycle.
REQ-013 RESP SHALL hold resp_valid_o=1 and stable response fields until resp_ready_i=1, then go to IDLE.
REQ-014 Minimum latency: accept in cycle N, SETUP in N+1, ACCESS in N+2 (pready_i=1), resp_valid_o in N+3, next accept in N+4 at the earliest.
REQ-015 Outside SETUP and ACCESS, psel_o, penable_o, pstrb_o and pwdata_o SHALL be 0, and paddr_o SHALL hold its last value.
REQ-016 SHALL ignore pready_i, pslverr_i and prdata_i outside ACCESS.
REQ-017 SHALL forward addresses unmodified, including unaligned addresses.

Reset
REQ-018 When rst_n_i=0 at a clock edge, the following edge SHALL bring the state to IDLE and all outputs to 0, except req_ready_o, which SHALL be 1 after the first edge with rst_n_i=1.
REQ-019 Reset during SETUP or ACCESS SHALL drop psel_o and penable_o at that edge; the in-flight transfer is discarded with no response.
REQ-020 SHALL clear the timeout counter on reset and on every entry to SETUP.

Structure
REQ-021 The shared package SHALL hold the FSM state enum and the APB4 PPROT default constant (3'b000).
REQ-022 The timeout counter SHALL be the sub-module apb4_bridge_timer, with start/clear and expired ports.
REQ-023 The bridge SHALL be able to drive apb4_gpio directly, with matching APB4 signal semantics.

Verification
REQ-024 Write 0xDEADBEEF to 0x04 with strb 4'hF and pready_i held at 1 -> psel_o in N+1, penable_o in N+2, resp_valid_o in N+3, resp_err_o=0.
REQ-025 Read 0x08 with pready_i low for 3 ACCESS cycles and prdata_i=0x1234_5678 on completion -> 4 ACCESS cycles, resp_rdata_o=0x1234_5678, APB outputs stable throughout.
REQ-026 Read with pslverr_i=1 at completion -> resp_err_o=1, resp_timeout_o=0.
REQ-027 With TIMEOUT=8 and pready_i held at 0 -> abort after 8 ACCESS cycles, resp_err_o=1, resp_timeout_o=1, resp_rdata_o=0, psel_o=0 on the next cycle.
REQ-028 With resp_ready_i=0 for 5 cycles -> resp_valid_o and data held for those 5 cycles, req_ready_o=0; with a second request pending, it is accepted 1 cycle after the response handshake.
REQ-029 rst_n_i=0 in the second ACCESS cycle -> psel_o=0 at the next edge, no response, IDLE, and a subsequent write completes normally.

Source files
------------

// File: rtl/apb4_master_bridge_pkg.sv
// Shared types and constants for the APB4 master bridge and its timeout timer.
package apb4_master_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } bridge_state_e;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

  // Wide enough for the largest legal TIMEOUT of 65535.
  localparam int TIMER_WIDTH = 16;

endpackage

// File: rtl/apb4_master_bridge_if.sv
// APB4 bus between the bridge (master modport) and a completer (slave modport).
interface apb4_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   paddr_o;
  logic [2:0]              pprot_o;
  logic                    psel_o;
  logic                    penable_o;
  logic                    pwrite_o;
  logic [DATA_WIDTH-1:0]   pwdata_o;
  logic [DATA_WIDTH/8-1:0] pstrb_o;
  logic                    pready_i;
  logic [DATA_WIDTH-1:0]   prdata_i;
  logic                    pslverr_i;

  modport master (
    output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  pready_i, prdata_i, pslverr_i
  );

  modport slave (
    input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output pready_i, prdata_i, pslverr_i
  );

endinterface

// File: rtl/apb4_bridge_timer.sv
// Counts ACCESS cycles; expired_o flags the TIMEOUT-th ACCESS cycle of a transfer.
module apb4_bridge_timer
  import apb4_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  logic [TIMER_WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      count_q <= '0;
    end else if (count_i) begin
      count_q <= count_q + TIMER_WIDTH'(1);
    end
  end

  // count_q holds the ACCESS cycles already spent, so the current one is count_q+1.
  assign expired_o = count_i && (count_q == TIMER_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/apb4_master_bridge.sv
// Request/response to APB4 master bridge with completer wait-state timeout.
module apb4_master_bridge
  import apb4_master_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_err_o,
  output logic                    resp_timeout_o,
  apb4_master_bridge_if.master    apb
);

  bridge_state_e state_q, state_d;

  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [2:0]              prot_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    tmo_q;
  logic                    live_q;
  logic                    accept;
  logic                    complete;
  logic                    abort;
  logic                    expired;
  logic                    bus_active;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && live_q) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        // A completing pready_i wins over a timeout landing in the same cycle.
        if (apb.pready_i) begin
          complete = 1'b1;
          state_d  = RESP;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // live_q keeps req_ready_o low until the first edge after reset is released.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      prot_q  <= PPROT_DEFAULT;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (accept) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        wstrb_q <= req_wstrb_i;
        prot_q  <= req_prot_i;
      end
      if (complete) begin
        rdata_q <= write_q ? '0 : apb.prdata_i;
        err_q   <= apb.pslverr_i;
        tmo_q   <= 1'b0;
      end else if (abort) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        tmo_q   <= 1'b1;
      end
    end
  end

  apb4_bridge_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (accept),
    .count_i  (state_q == ACCESS),
    .expired_o(expired)
  );

  assign bus_active     = (state_q == SETUP) || (state_q == ACCESS);
  assign req_ready_o    = (state_q == IDLE) && live_q;
  assign resp_valid_o   = (state_q == RESP);
  assign resp_rdata_o   = rdata_q;
  assign resp_err_o     = err_q;
  assign resp_timeout_o = tmo_q;

  assign apb.paddr_o   = addr_q;
  assign apb.pprot_o   = prot_q;
  assign apb.pwrite_o  = write_q;
  assign apb.psel_o    = bus_active;
  assign apb.penable_o = (state_q == ACCESS);
  assign apb.pwdata_o  = (bus_active && write_q) ? wdata_q : '0;
  assign apb.pstrb_o   = (bus_active && write_q) ? wstrb_q : '0;

endmodule
